// File: rtl/shift_pkg.sv
// Shared types and sizing for the sequential left shifter.
package shift_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SHAMT_W_DEF = 5;
  localparam int unsigned NUM_STAGES  = 5;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shl_stage.sv
// One binary-weighted left-shift stage (distance 2^idx) with its overflow bit.
module shl_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = CNT_W
) (
  input  logic [WIDTH-1:0] value,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] shifted,
  output logic             stage_ovf
);

  logic [WIDTH-1:0]      sh_arr [NUM_STAGES];
  logic [NUM_STAGES-1:0] ov_arr;

  // Each stage loses signed range unless the bits shifted past the sign are copies of it.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    localparam int unsigned DIST = 1 << g;
    logic [DIST:0] top;
    assign top       = value[WIDTH-1 -: DIST+1];
    assign sh_arr[g] = value << DIST;
    assign ov_arr[g] = !((&top) || !(|top));
  end

  always_comb begin
    shifted   = value;
    stage_ovf = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx == IDX_W'(k)) begin
        shifted   = sh_arr[k];
        stage_ovf = ov_arr[k];
      end
    end
  end

endmodule

// File: rtl/sll_seq_shifter.sv
// Multi-cycle 32-bit shift-left with sticky signed-overflow flag, valid/ready on both sides.
module sll_seq_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               ovf
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] amt;
  logic               flag;

  logic               accept;
  logic               amt_bit;
  logic               last_stage;
  logic [WIDTH-1:0]   stage_val;
  logic               stage_ovf;

  assign amt_bit    = |(amt & (SHAMT_W'(1) << cnt));
  assign last_stage = (cnt == CNT_W'(NUM_STAGES - 1));

  shl_stage #(
    .WIDTH (WIDTH),
    .IDX_W (CNT_W)
  ) u_stage (
    .value     (work),
    .idx       (cnt),
    .shifted   (stage_val),
    .stage_ovf (stage_ovf)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake; a retiring DONE may immediately take the next request.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_stage) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!resetn) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  assign accept   = in_valid && in_ready;
  assign data_out = out_valid ? work : '0;
  assign ovf      = out_valid && flag;

  // Work/amount/flag datapath: every stage runs, unselected stages just hold.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt  <= '0;
      work <= '0;
      amt  <= '0;
      flag <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      work <= data_in;
      amt  <= shamt;
      flag <= 1'b0;
    end else if (state == SHIFT) begin
      if (amt_bit) begin
        work <= stage_val;
        flag <= flag | stage_ovf;
      end
      cnt <= last_stage ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sll_seq_shifter.sv
// Self-checking bench for sll_seq_shifter: directed table, handshake sequences, random ops.
module tb_sll_seq_shifter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        ovf;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] exp_d;
    logic        exp_o;
  } vec_t;

  sll_seq_shifter dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference: exact product vs. the 32-bit wrapped result, both as signed integers.
  function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [4:0] s);
    return d << s;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] d, input logic [4:0] s);
    longint      full;
    longint      got;
    logic [31:0] r;
    r    = d << s;
    full = longint'($signed(d)) * (longint'(1) << s);
    got  = longint'($signed(r));
    return full != got;
  endfunction

  // Called on a negedge with the unit idle; returns at the negedge after the retire edge.
  task automatic do_op(input logic [31:0] d, input logic [4:0] s, input int stall,
                       output logic [31:0] r, output logic o, output int lat);
    int guard;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    data_in   = d;
    shamt     = s;
    guard     = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    chk("accept_ready", 64'(in_ready), 64'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    data_in  = $urandom;
    shamt    = 5'($urandom);
    lat      = 0;
    while (lat < 20) begin
      @(negedge clock);
      if (out_valid) break;
      lat++;
    end
    r = data_out;
    o = ovf;
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clock);
        chk("hold", 64'({out_valid, in_ready, ovf, data_out}), 64'({1'b1, 1'b0, o, r}));
      end
      out_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    @(negedge clock);
  endtask

  initial begin
    vec_t        tbl [8];
    logic [31:0] r;
    logic        o;
    int          lat;

    tbl[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1};
    tbl[1] = '{32'hFFFF_FFF0, 5'd4,  32'hFFFF_FF00, 1'b0};
    tbl[2] = '{32'h4000_0000, 5'd1,  32'h8000_0000, 1'b1};
    tbl[3] = '{32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
    tbl[4] = '{32'h0000_00FF, 5'd8,  32'h0000_FF00, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0};
    tbl[6] = '{32'h7FFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b1};
    tbl[7] = '{32'hC000_0000, 5'd1,  32'h8000_0000, 1'b0};

    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    shamt     = '0;
    repeat (3) @(negedge clock);
    chk("reset_outs", 64'({in_ready, out_valid, ovf, data_out}), 64'(0));
    resetn = 1'b1;
    #1;
    chk("post_reset_ready", 64'({in_ready, out_valid}), 64'(2'b10));

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].d, tbl[i].s, 0, r, o, lat);
      chk($sformatf("tbl%0d_data", i), 64'(r), 64'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_ovf", i), 64'(o), 64'(tbl[i].exp_o));
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(5));
    end

    // Back-to-back with in_valid and out_ready held high
    begin : b2b
      logic [31:0] ops [3];
      logic [4:0]  sh  [3];
      logic [31:0] ex  [3];
      int          acc_cyc [3];
      logic        coinc   [3];
      int          ai;
      int          ri;
      int          cyc;
      logic        acc_now;
      logic        ret_now;
      ops[0] = 32'h1; ops[1] = 32'h3; ops[2] = 32'h7;
      sh[0]  = 5'd1;  sh[1]  = 5'd2;  sh[2]  = 5'd3;
      ex[0]  = 32'h2; ex[1]  = 32'hC; ex[2]  = 32'h38;
      for (int i = 0; i < 3; i++) begin
        acc_cyc[i] = 0;
        coinc[i]   = 1'b0;
      end
      ai = 0; ri = 0; cyc = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      data_in   = ops[0];
      shamt     = sh[0];
      while (ri < 3 && cyc < 60) begin
        acc_now = in_valid && in_ready;
        ret_now = out_valid && out_ready;
        if (ret_now) begin
          chk($sformatf("b2b_data%0d", ri), 64'(data_out), 64'(ex[ri]));
          ri++;
        end
        if (acc_now && ai < 3) begin
          acc_cyc[ai] = cyc;
          coinc[ai]   = ret_now;
          ai++;
        end
        @(posedge clock);
        #1;
        if (acc_now) begin
          if (ai < 3) begin
            data_in = ops[ai];
            shamt   = sh[ai];
          end else begin
            in_valid = 1'b0;
          end
        end
        @(negedge clock);
        cyc++;
      end
      in_valid = 1'b0;
      chk("b2b_results", 64'(ri), 64'(3));
      chk("b2b_space1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(6));
      chk("b2b_space2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(6));
      chk("b2b_coincide", 64'({coinc[1], coinc[2]}), 64'(2'b11));
    end

    // Backpressure: 10 extra cycles held in DONE, then retire and idle
    do_op(32'h0000_0003, 5'd30, 10, r, o, lat);
    chk("bp_data", 64'(r), 64'(32'hC000_0000));
    chk("bp_ovf", 64'(o), 64'(1));
    chk("bp_idle", 64'({out_valid, in_ready, ovf, data_out}), 64'({1'b0, 1'b1, 1'b0, 32'h0}));

    // Reset while the stage counter sits at 2
    in_valid = 1'b1;
    data_in  = 32'hDEAD_BEEF;
    shamt    = 5'd7;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("rst_comb", 64'({in_ready, out_valid, ovf, data_out}), 64'(0));
    @(posedge clock);
    @(negedge clock);
    chk("rst_outs", 64'({in_ready, out_valid, ovf, data_out}), 64'(0));
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("rst_release", 64'({in_ready, out_valid}), 64'(2'b10));
    @(negedge clock);
    chk("rst_stays_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    do_op(32'h0000_00FF, 5'd8, 0, r, o, lat);
    chk("rst_fresh_data", 64'(r), 64'(32'h0000_FF00));
    chk("rst_fresh_ovf", 64'(o), 64'(0));
    chk("rst_fresh_lat", 64'(lat), 64'(5));

    // Random operations against the arithmetic reference
    for (int i = 0; i < 120; i++) begin
      logic [31:0] d;
      logic [4:0]  s;
      int          stall;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 255));
        2:       d = ~(32'($urandom_range(0, 255)));
        default: d = 32'h1 << $urandom_range(0, 31);
      endcase
      s     = 5'($urandom_range(0, 31));
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_op(d, s, stall, r, o, lat);
      chk($sformatf("rnd%0d_data d=%h s=%0d", i, d, s), 64'(r), 64'(ref_data(d, s)));
      chk($sformatf("rnd%0d_ovf d=%h s=%0d", i, d, s), 64'(o), 64'(ref_ovf(d, s)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
